// File: rtl/b01_resp_checker_if.sv
// Response-checker bus: run control, DUT observation and expected table port.
// Optional capture port enabled by B01_RESP_CHECKER_CAPTURE_EN.
interface b01_resp_checker_if;
    logic       start;
    logic       stop;
    logic       outp;
    logic       overflw;
    logic       exp_we;
    logic [3:0] exp_addr;
    logic [2:0] exp_data;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic [3:0] first_err_idx;
    logic       first_err_vld;
`ifdef B01_RESP_CHECKER_CAPTURE_EN
    logic [3:0] cap_addr;
    logic [1:0] cap_data;

    modport master (
        output start, stop, outp, overflw,
        output exp_we, exp_addr, exp_data, cap_addr,
        input  busy, done, pass, err_count,
        input  first_err_idx, first_err_vld, cap_data
    );

    modport slave (
        input  start, stop, outp, overflw,
        input  exp_we, exp_addr, exp_data, cap_addr,
        output busy, done, pass, err_count,
        output first_err_idx, first_err_vld, cap_data
    );
`else
    modport master (
        output start, stop, outp, overflw,
        output exp_we, exp_addr, exp_data,
        input  busy, done, pass, err_count,
        input  first_err_idx, first_err_vld
    );

    modport slave (
        input  start, stop, outp, overflw,
        input  exp_we, exp_addr, exp_data,
        output busy, done, pass, err_count,
        output first_err_idx, first_err_vld
    );
`endif
endinterface

// File: rtl/b01_resp_checker.sv
// Per-cycle response checker against a DEPTH-entry expected table.
// Optional response capture enabled by B01_RESP_CHECKER_CAPTURE_EN.
module b01_resp_checker #(
    parameter int DEPTH = 10
) (
    input logic              clock,
    input logic              reset,
    b01_resp_checker_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t     state;
    logic [3:0] idx;
    logic [4:0] err_q;
    logic [3:0] first_idx_q;
    logic       first_vld_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;

    logic [2:0] tbl [DEPTH];
    logic [2:0] cur;
    logic       miss;
    logic       last;
    logic [4:0] err_nxt;
    logic       wr_ok;

    assign cur     = tbl[idx];
    assign miss    = cur[2] &
                     ((bus.outp != cur[0]) |
                      (bus.overflw != cur[1]));
    assign last    = ({1'b0, idx} == 5'(DEPTH - 1));
    assign err_nxt = err_q + {4'd0, miss};
    assign wr_ok   = bus.exp_we && (state != RUN) &&
                     ({1'b0, bus.exp_addr} < 5'(DEPTH));

    // Table has no reset; contents survive reset.
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            tbl[bus.exp_addr] <= bus.exp_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= 4'd0;
            err_q       <= 5'd0;
            first_idx_q <= 4'd0;
            first_vld_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else if (bus.stop) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state       <= RUN;
                        idx         <= 4'd0;
                        err_q       <= 5'd0;
                        first_idx_q <= 4'd0;
                        first_vld_q <= 1'b0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                    end
                end
                RUN: begin
                    idx   <= idx + 4'd1;
                    err_q <= err_nxt;
                    if (miss && !first_vld_q) begin
                        first_idx_q <= idx;
                        first_vld_q <= 1'b1;
                    end
                    if (last) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= (err_nxt == 5'd0);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    pass_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.err_count     = err_q;
    assign bus.first_err_idx = first_idx_q;
    assign bus.first_err_vld = first_vld_q;

`ifdef B01_RESP_CHECKER_CAPTURE_EN
    logic [1:0] cap [DEPTH];

    always_ff @(posedge clock) begin
        if (reset && !bus.stop && (state == RUN)) begin
            cap[idx] <= {bus.overflw, bus.outp};
        end
    end

    assign bus.cap_data =
        ({1'b0, bus.cap_addr} < 5'(DEPTH)) ?
        cap[bus.cap_addr] : 2'b00;
`endif

endmodule
